// File: rtl/serial_sub.sv
// serial_sub: bit-serial subtractor computing diff = a - b - bin over WIDTH
// cycles, LSB first, through one full-subtractor cell and a registered borrow.
// Optional signed-overflow output is enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-2:0] res_q, res_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             done_q, done_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic             ai, bi, d_bit, br_nxt, last_bit;
  logic [WIDTH-1:0] res_shift;

  // Full-subtractor cell on the current operand LSBs and the borrow flop.
  always_comb begin
    ai        = a_q[0];
    bi        = b_q[0];
    d_bit     = ai ^ bi ^ br_q;
    br_nxt    = (~ai & bi) | (~(ai ^ bi) & br_q);
    last_bit  = (cnt_q == CW'(WIDTH - 1));
    // Result register is one bit short: on the final edge the new bit
    // joins it directly to form the complete WIDTH-bit difference.
    res_shift = {d_bit, res_q};
  end

  // Next-state and datapath control for the IDLE/RUN sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    br_d    = br_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    done_d  = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          cnt_d   = '0;
          res_d   = '0;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = res_shift[WIDTH-1:1];
        br_d  = br_nxt;
        cnt_d = cnt_q + CW'(1);
        if (last_bit) begin
          state_d = IDLE;
          diff_d  = res_shift;
          bout_d  = br_nxt;
          done_d  = 1'b1;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = br_q ^ br_nxt;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      br_q    <= br_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      done_q  <= done_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: doc/serial_sub.md
# serial_sub

Bit-serial, parametrised multi-bit subtractor computing `diff = a - b - bin` over WIDTH clock cycles, LSB first, using a single full-subtractor cell and a registered borrow. It is the sequential successor to the team's single-bit half/full subtractor cells. It targets area-constrained datapaths where one result every WIDTH+1 cycles is sufficient. It uses a start/busy/done handshake so a controller can issue operations back-to-back.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range is WIDTH >= 2.
- `clk`  input  1  rising-edge clock; the only clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  request; sampled only when idle.
- `a`  input  WIDTH  minuend; captured on the accepting edge.
- `b`  input  WIDTH  subtrahend; captured on the accepting edge.
- `bin`  input  1  initial borrow-in; captured on the accepting edge.
- `busy`  output  1  high while an operation is in progress.
- `done`  output  1  one-cycle pulse marking a valid result.
- `diff`  output  WIDTH  result, held until the next completion.
- `bout`  output  1  final borrow out of the MSB, held with `diff`.
- `ovf`  output  1  signed overflow flag; present only with SERIAL_SUB_OVF_EN.

## Operation
- FSM has two states, IDLE and RUN. Reset state is IDLE.
- IDLE → RUN: on a clock edge where `start`=1.
  - Latch `a` and `b` into operand shift registers.
  - Load the borrow flop with `bin`.
  - Clear the bit counter (width $clog2(WIDTH)).
- RUN, each edge, with bit i = counter value, ai/bi the current LSBs of the shift registers and br the borrow flop:
  - Difference bit d = ai ^ bi ^ br.
  - Next borrow br' = (~ai & bi) | (~(ai ^ bi) & br).
  - d shifts into the MSB of the result shift register; the operand registers shift right.
  - The counter increments.
- RUN → IDLE: on the edge that processes bit WIDTH-1. On that same edge:
  - `diff` is loaded from the completed result (including the final bit).
  - `bout` is loaded with br'.
  - `done` is set.
- `diff` and `bout` never show partial results. They change only on a completion edge or on reset.
- `start` while busy is ignored: no operand capture and no effect on the running operation.
- Arithmetic is modulo 2^WIDTH. `bout`=1 exactly when the unsigned value a < b + bin.
- Reset mid-operation clears all state immediately. The aborted operation produces no `done` pulse.

## Timing
- Reset values: `busy`=0, `done`=0, `diff`=0, `bout`=0, `ovf`=0. State is IDLE; counter, borrow and shift registers are 0.
- Let edge 0 be the edge that accepts `start`.
  - Edges 1..WIDTH process bits 0..WIDTH-1.
  - `busy` is high from after edge 0 through the cycle ending at edge WIDTH.
  - `done` is high for exactly the one cycle between edges WIDTH and WIDTH+1.
  - `busy` and `done` are never high together.
- Latency is WIDTH edges from start acceptance to the result being visible.
- During the `done` cycle the FSM is already in IDLE. A `start` in that cycle is accepted at edge WIDTH+1.
- Back-to-back throughput is one result per WIDTH+1 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `SERIAL_SUB_OVF_EN`.
- When defined:
  - `ovf` port exists and is loaded on the completion edge.
  - `ovf` = (borrow into bit WIDTH-1) XOR (borrow out of bit WIDTH-1), i.e. signed two's-complement overflow of a - b - bin.
  - `ovf` holds with `diff` and resets to 0.
- When undefined: the `ovf` port and its logic are absent. All other behaviour is identical.

## Test plan
- WIDTH=8, a=0x5A, b=0x23, bin=0, start at edge 0:
  - `busy` is high for 8 cycles.
  - `done` pulses in the cycle after edge 8.
  - Result: diff=0x37, bout=0.
- a=0x10, b=0x20, bin=0 → diff=0xF0, bout=1, ovf=0.
- a=0x00, b=0x00, bin=1 → diff=0xFF, bout=1.
- Overflow cases (SERIAL_SUB_OVF_EN defined):
  - a=0x80, b=0x01 → diff=0x7F, bout=0, ovf=1.
  - a=0x7F, b=0xFF → diff=0x80, bout=1, ovf=1.
- Handshake:
  - Start (0x05,0x03). Drive start=1 with a=0xFF, b=0x00 at edge 3 → ignored; result is diff=0x02.
  - Start=1 held during the `done` cycle with (0x09,0x04) → accepted immediately; the second done gives diff=0x05.
- Drive rst_n low at edge 4 of a run:
  - All outputs go to 0 immediately; no `done` pulse follows.
  - After release, a new start (0x03,0x01) gives diff=0x02 with standard latency.
